fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 37 +++
 rtl/fetch_unit_pc_next.sv | 47 ++++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit_pkg
// Brief   : FSM state encodings, opcode constants and IR field positions
//           shared across the fetch unit.
// Revision: 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [3:0] c_OP_NOOP = 4'h0;
    localparam logic [3:0] c_OP_LOD  = 4'h1;
    localparam logic [3:0] c_OP_STR  = 4'h2;
    localparam logic [3:0] c_OP_BRA  = 4'h4;
    localparam logic [3:0] c_OP_BRR  = 4'h5;
    localparam logic [3:0] c_OP_BNE  = 4'h6;
    localparam logic [3:0] c_OP_ALU  = 4'h8;
    localparam logic [3:0] c_OP_HLT  = 4'hF;

    localparam int c_OPC_MSB = 31;
    localparam int c_OPC_LSB = 28;
    localparam int c_MM_MSB  = 27;
    localparam int c_MM_LSB  = 24;
    localparam int c_IMM_MSB = 15;
    localparam int c_IMM_LSB = 0;

    function automatic logic is_halt(input logic [31:0] instr);
        return instr[c_OPC_MSB:c_OPC_LSB] == c_OP_HLT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
`default_nettype none
// ============================================================================
// Module  : pc_next
// Brief   : Combinational next-PC selection: hold, increment, relative or
//           absolute branch, all modulo 2^ADDR_W.
// Revision: 1.0  initial release
// ============================================================================
module pc_next #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [15:0]       i_imm,
    input  logic [ADDR_W-1:0] i_abs_target,
    input  logic              i_first,
    input  logic              i_pc_sel,
    input  logic              i_br_sel,
    output logic [ADDR_W-1:0] o_next_pc
);

    logic [ADDR_W-1:0] w_offset;

    // Offset is sign-extended or truncated to the PC width so the add wraps naturally
    generate
        if (ADDR_W > 16) begin : g_ext
            assign w_offset = {{(ADDR_W-16){i_imm[15]}}, i_imm};
        end else if (ADDR_W == 16) begin : g_same
            assign w_offset = i_imm;
        end else begin : g_trunc
            assign w_offset = i_imm[ADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        o_next_pc = i_pc;
        if (i_first) begin
            o_next_pc = i_pc;
        end else if (!i_pc_sel) begin
            o_next_pc = i_pc + ADDR_W'(1);
        end else if (!i_br_sel) begin
            o_next_pc = i_pc + w_offset;
        end else begin
            o_next_pc = i_abs_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Instruction fetch unit: PC register, IMEM request handshake,
//           instruction register, one-deep pending fetch and halt latch.
// Revision: 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST_F,
    input  logic              PC_WRITE,
    input  logic              PC_SEL,
    input  logic              BR_SEL,
    input  logic              PC_RST,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [31:0]       IMEM_RDATA,
    output logic [31:0]       IR,
    output logic [3:0]        OPCODE,
    output logic [3:0]        MM,
    output logic [ADDR_W-1:0] PC,
    output logic              IR_VALID,
    output logic              FETCH_BUSY,
    output logic              HALTED
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_ir;
    logic              r_ir_valid;
    logic              r_halted;
    logic              r_pending;
    logic              r_first;
    logic              r_pc_write_d;
    logic              w_pw_rise;
    logic              w_launch;
    logic              w_busy;
    logic              w_ack_take;
    logic [ADDR_W-1:0] w_pc_nxt;

    assign w_pw_rise  = PC_WRITE & ~r_pc_write_d;
    assign w_ack_take = (r_state == ST_REQ) && IMEM_ACK && !PC_RST;

    pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .i_pc         (r_pc),
        .i_imm        (r_ir[c_IMM_MSB:c_IMM_LSB]),
        .i_abs_target (r_ir[ADDR_W-1:0]),
        .i_first      (r_first),
        .i_pc_sel     (PC_SEL),
        .i_br_sel     (BR_SEL),
        .o_next_pc    (w_pc_nxt)
    );

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_launch    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_launch = !PC_RST && !r_halted && (w_pw_rise || r_pending);
                if (w_launch) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_busy = 1'b1;
                // An ACK coinciding with PC_RST completes the bus cycle; its data is dropped
                if (IMEM_ACK) begin
                    w_state_nxt = ST_IDLE;
                end else if (PC_RST) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                w_busy = 1'b1;
                if (IMEM_ACK) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            r_pc         <= RESET_PC;
            r_imem_addr  <= RESET_PC;
            r_ir         <= '0;
            r_ir_valid   <= 1'b0;
            r_halted     <= 1'b0;
            r_pending    <= 1'b0;
            r_first      <= 1'b1;
            r_pc_write_d <= 1'b0;
        end else begin
            r_pc_write_d <= PC_WRITE;
            if (PC_RST) begin
                r_pc       <= RESET_PC;
                r_ir_valid <= 1'b0;
                r_pending  <= 1'b0;
                r_first    <= 1'b1;
                r_halted   <= 1'b0;
            end else begin
                if (w_launch) begin
                    r_pc        <= w_pc_nxt;
                    r_imem_addr <= w_pc_nxt;
                    r_ir_valid  <= 1'b0;
                    r_first     <= 1'b0;
                    r_pending   <= 1'b0;
                end else if (r_halted) begin
                    r_pending <= 1'b0;
                end else if (w_busy && w_pw_rise) begin
                    r_pending <= 1'b1;
                end
                if (w_ack_take) begin
                    r_ir       <= IMEM_RDATA;
                    r_ir_valid <= 1'b1;
                    r_halted   <= is_halt(IMEM_RDATA);
                end
            end
        end
    end

    // Address register only moves on launch so it stays stable through DROP
    assign IMEM_REQ   = w_busy;
    assign FETCH_BUSY = w_busy;
    assign IMEM_ADDR  = r_imem_addr;
    assign IR         = r_ir;
    assign OPCODE     = r_ir[c_OPC_MSB:c_OPC_LSB];
    assign MM         = r_ir[c_MM_MSB:c_MM_LSB];
    assign PC         = r_pc;
    assign IR_VALID   = r_ir_valid;
    assign HALTED     = r_halted;

endmodule
`default_nettype wire
